fusion_accum: RTL and testbench

FUSION_ACCUM -- requirements
Module: fusion_accum

---
 rtl/fusion_accum.sv | 172 +++++++++++++++++
 tb/tb_fusion_accum.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fusion_accum.sv
`default_nettype none
// ============================================================================
// Module      : fusion_accum
// Description : Four-lane saturating accumulator for packed fusion-unit
//               products. A start pulse opens a run of len beats. Each
//               accepted beat is split into 16/32-bit lanes, extended and
//               added with clamping. The result is then held until it is
//               consumed.
// Revision    : 1.0 - initial release
// ============================================================================
module fusion_accum #(
   parameter int ACC_W = 32,   // lane accumulator width, must be >= 32
   parameter int CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [CNT_W-1:0]     len,
   input  logic [1:0]           mode,
   input  logic                 sgn,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [63:0]          in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [4*ACC_W-1:0]   out_data,
   output logic                 sat,
   output logic                 busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ACCUM = 2'b01,
      DRAIN = 2'b10
   } state_t;

   state_t             state;
   state_t             state_nxt;

   logic [ACC_W-1:0]   acc     [4];
   logic [ACC_W-1:0]   acc_nxt [4];
   logic [31:0]        lane_raw[4];
   logic [3:0]         lane_sat;
   logic               sat_q;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   len_q;
   logic [1:0]         mode_q;
   logic               sgn_q;

   logic               accept;
   logic               last_beat;
   logic [CNT_W-1:0]   eff_len;
   logic [CNT_W-1:0]   cnt_inc;

   assign accept    = in_valid && (state == ACCUM);
   // A zero length still consumes exactly one product.
   assign eff_len   = (len_q == '0) ? CNT_W'(1) : len_q;
   assign cnt_inc   = cnt + CNT_W'(1);
   assign last_beat = accept && (cnt_inc == eff_len);

   // Split the packed product into four 32-bit lanes using the latched layout.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         lane_raw[i] = '0;
      end
      case (mode_q)
         2'b01: begin
            lane_raw[0] = in_data[31:0];
            lane_raw[1] = in_data[63:32];
         end
         2'b10: begin
            lane_raw[0] = in_data[31:0];
         end
         default: begin
            for (int i = 0; i < 4; i++) begin
               lane_raw[i] = {{16{sgn_q & in_data[16*i+15]}}, in_data[16*i +: 16]};
            end
         end
      endcase
   end

   // Per-lane add in ACC_W+1 bits, then clamp to the signed or unsigned range.
   for (genvar i = 0; i < 4; i++) begin : g_lane
      logic [ACC_W:0]   lane_ext;
      logic [ACC_W:0]   acc_ext;
      logic [ACC_W:0]   sum;
      logic [ACC_W-1:0] clamped;
      logic             ovf;

      assign lane_ext = {{(ACC_W-31){sgn_q & lane_raw[i][31]}}, lane_raw[i]};
      assign acc_ext  = {sgn_q & acc[i][ACC_W-1], acc[i]};
      assign sum      = acc_ext + lane_ext;

      // Signed overflow shows as disagreeing top two bits; unsigned as a carry.
      always_comb begin
         clamped = sum[ACC_W-1:0];
         ovf     = 1'b0;
         if (sgn_q) begin
            if (sum[ACC_W] != sum[ACC_W-1]) begin
               ovf     = 1'b1;
               clamped = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                    : {1'b0, {(ACC_W-1){1'b1}}};
            end
         end else if (sum[ACC_W]) begin
            ovf     = 1'b1;
            clamped = {ACC_W{1'b1}};
         end
      end

      assign acc_nxt[i]                 = clamped;
      assign lane_sat[i]                = ovf;
      assign out_data[ACC_W*i +: ACC_W] = acc[i];
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode; start only matters in IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start)     state_nxt = ACCUM;
         ACCUM:   if (last_beat) state_nxt = DRAIN;
         DRAIN:   if (out_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   // Run setup on start, then accumulate every accepted beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            acc[i] <= '0;
         end
         sat_q  <= 1'b0;
         cnt    <= '0;
         len_q  <= '0;
         mode_q <= '0;
         sgn_q  <= 1'b0;
      end else if (state == IDLE && start) begin
         for (int i = 0; i < 4; i++) begin
            acc[i] <= '0;
         end
         sat_q  <= 1'b0;
         cnt    <= '0;
         len_q  <= len;
         mode_q <= mode;
         sgn_q  <= sgn;
      end else if (accept) begin
         for (int i = 0; i < 4; i++) begin
            acc[i] <= acc_nxt[i];
         end
         cnt <= cnt_inc;
         if (|lane_sat) begin
            sat_q <= 1'b1;
         end
      end
   end

   assign in_ready  = (state == ACCUM);
   assign out_valid = (state == DRAIN);
   assign busy      = (state != IDLE);
   assign sat       = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_fusion_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_fusion_accum
// Description : Directed bench for fusion_accum with a result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fusion_accum;

   localparam int ACC_W = 32;
   localparam int CNT_W = 8;

   logic               clk       = 1'b0;
   logic               rst_n     = 1'b0;
   logic               start     = 1'b0;
   logic [CNT_W-1:0]   len       = '0;
   logic [1:0]         mode      = '0;
   logic               sgn       = 1'b0;
   logic               in_valid  = 1'b0;
   logic               in_ready;
   logic [63:0]        in_data   = '0;
   logic               out_valid;
   logic               out_ready = 1'b0;
   logic [4*ACC_W-1:0] out_data;
   logic               sat;
   logic               busy;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [4*ACC_W-1:0] data;
      logic               sat;
   } exp_t;

   exp_t sb[$];

   fusion_accum #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .len       (len),
      .mode      (mode),
      .sgn       (sgn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .sat       (sat),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] lanes4(input logic [31:0] l3, input logic [31:0] l2,
                                           input logic [31:0] l1, input logic [31:0] l0);
      return {l3, l2, l1, l0};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at a negedge with start low again.
   task automatic start_run(input logic [CNT_W-1:0] l, input logic [1:0] m, input logic s);
      start = 1'b1;
      len   = l;
      mode  = m;
      sgn   = s;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Called at a negedge; holds the beat until accepted, returns at a negedge.
   task automatic send_beat(input logic [63:0] d);
      int n;
      n        = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("beat_accept_timeout", in_ready, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // Waits for a result, compares against the scoreboard head, handshakes.
   task automatic get_result(input string tag, input logic start_too);
      int   n;
      exp_t e;
      n = 0;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_valid"}, out_valid, 1'b1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, "_data"}, out_data, e.data);
         chk({tag, "_sat"}, sat, e.sat);
      end
      out_ready = 1'b1;
      start     = start_too;
      @(negedge clk);
      out_ready = 1'b0;
      start     = 1'b0;
      chk({tag, "_idle"}, busy, 1'b0);
   endtask

   initial begin
      logic [127:0] bp_exp;

      // Reset state
      @(negedge clk);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_out_data", out_data, '0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);
      chk("post_rst_busy", busy, 1'b0);

      // Mode 00 signed, three beats of -1 per lane
      start_run(8'd3, 2'b00, 1'b1);
      chk("t1_in_ready", in_ready, 1'b1);
      sb.push_back('{data: lanes4(32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFD), sat: 1'b0});
      send_beat(64'hFFFF_FFFF_FFFF_FFFF);
      send_beat(64'hFFFF_FFFF_FFFF_FFFF);
      chk("t1_no_early_valid", out_valid, 1'b0);
      send_beat(64'hFFFF_FFFF_FFFF_FFFF);
      chk("t1_latency", out_valid, 1'b1);
      get_result("t1", 1'b0);

      // Mode 01 unsigned, two 32-bit lanes
      start_run(8'd2, 2'b01, 1'b0);
      sb.push_back('{data: lanes4(32'h0, 32'h0, 32'h5, 32'h5), sat: 1'b0});
      send_beat({32'h2, 32'h1});
      send_beat({32'h3, 32'h4});
      get_result("t2", 1'b0);

      // Mode 10 signed positive saturation, upper half ignored
      start_run(8'd2, 2'b10, 1'b1);
      sb.push_back('{data: lanes4(32'h0, 32'h0, 32'h0, 32'h7FFFFFFF), sat: 1'b1});
      send_beat(64'hDEAD_BEEF_7FFF_FFFF);
      send_beat(64'hDEAD_BEEF_7FFF_FFFF);
      get_result("t3", 1'b0);

      // Mode 10 unsigned saturation
      start_run(8'd2, 2'b10, 1'b0);
      sb.push_back('{data: lanes4(32'h0, 32'h0, 32'h0, 32'hFFFFFFFF), sat: 1'b1});
      send_beat(64'h0000_0000_FFFF_FFFF);
      send_beat(64'h0000_0000_FFFF_FFFF);
      get_result("t4", 1'b0);

      // Mode 01 signed negative saturation on lane 0 only
      start_run(8'd2, 2'b01, 1'b1);
      sb.push_back('{data: lanes4(32'h0, 32'h0, 32'h2, 32'h80000000), sat: 1'b1});
      send_beat({32'h1, 32'h80000000});
      send_beat({32'h1, 32'h80000000});
      get_result("t5", 1'b0);

      // Mode 11 behaves as 00
      start_run(8'd1, 2'b11, 1'b0);
      sb.push_back('{data: lanes4(32'd4, 32'd3, 32'd2, 32'd1), sat: 1'b0});
      send_beat({16'd4, 16'd3, 16'd2, 16'd1});
      get_result("t6", 1'b0);

      // len=0 takes one beat; signed 16-bit extension
      start_run(8'd0, 2'b00, 1'b1);
      sb.push_back('{data: lanes4(32'hFFFFFFFE, 32'h00007FFF, 32'hFFFF8000, 32'h00000001), sat: 1'b0});
      send_beat(64'hFFFE_7FFF_8000_0001);
      chk("t7_one_beat", out_valid, 1'b1);
      chk("t7_in_ready", in_ready, 1'b0);
      get_result("t7", 1'b0);

      // Back-pressure in DRAIN, start and in_valid ignored
      start_run(8'd2, 2'b00, 1'b0);
      bp_exp = lanes4(32'd8, 32'd6, 32'd4, 32'd2);
      sb.push_back('{data: bp_exp, sat: 1'b0});
      send_beat({16'd4, 16'd3, 16'd2, 16'd1});
      send_beat({16'd4, 16'd3, 16'd2, 16'd1});
      for (int c = 0; c < 5; c++) begin
         start    = (c == 2);
         len      = 8'd1;
         in_valid = 1'b1;
         in_data  = 64'h0001_0001_0001_0001;
         @(negedge clk);
         chk("bp_data_stable", out_data, bp_exp);
         chk("bp_in_ready", in_ready, 1'b0);
         chk("bp_out_valid", out_valid, 1'b1);
      end
      start    = 1'b0;
      in_valid = 1'b0;
      get_result("t8", 1'b1);
      idle(1);
      chk("t8_start_at_handshake_ignored", busy, 1'b0);

      // Gaps between beats stall the counter
      start_run(8'd3, 2'b10, 1'b0);
      sb.push_back('{data: lanes4(32'h0, 32'h0, 32'h0, 32'd60), sat: 1'b0});
      send_beat(64'd10);
      idle(3);
      chk("t9_gap_busy", busy, 1'b1);
      send_beat(64'd20);
      idle(2);
      chk("t9_gap_no_valid", out_valid, 1'b0);
      send_beat(64'd30);
      get_result("t9", 1'b0);

      // Reset mid-run abandons the run
      start_run(8'd4, 2'b10, 1'b0);
      send_beat(64'd7);
      rst_n = 1'b0;
      #1;
      chk("t10_rst_out_valid", out_valid, 1'b0);
      chk("t10_rst_in_ready", in_ready, 1'b0);
      chk("t10_rst_busy", busy, 1'b0);
      chk("t10_rst_out_data", out_data, '0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);
      chk("t10_post_busy", busy, 1'b0);
      chk("t10_post_valid", out_valid, 1'b0);
      start_run(8'd1, 2'b10, 1'b0);
      sb.push_back('{data: lanes4(32'h0, 32'h0, 32'h0, 32'd5), sat: 1'b0});
      send_beat(64'd5);
      get_result("t10", 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
